// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key schedule and the round cores:
//   - ks_state_e     : key-schedule FSM states
//   - sbox()         : forward S-box lookup
//   - rcon()         : round constant, index 0 -> 8'h01 (Rcon[1] in FIPS-197)
//   - nr_of()        : number of rounds for a given key width
//   - inv_mix_col()  : InvMixColumns applied to one 32-bit column
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } ks_state_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Ten round constants, enough for every key size (AES-128 uses all ten).
  localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return RCON_TABLE[79 - 8*int'(idx) -: 8];
  endfunction

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant in GF(2^8); covers 9, 11, 13 and 14.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9),
            gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13),
            gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11),
            gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14)};
  endfunction

endpackage

// File: rtl/aes_subword.sv
// -----------------------------------------------------------------------------
// aes_subword
// Combinational SubWord with optional RotWord in front of it.
//   word_in  [31:0]  input word, byte 0 in [31:24]
//   rot              1: rotate left by one byte before substitution
//   word_out [31:0]  substituted word
// -----------------------------------------------------------------------------
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic        rot,
  output logic [31:0] word_out
);

  logic [31:0] pre;

  assign pre      = rot ? {word_in[23:0], word_in[31:24]} : word_in;
  assign word_out = {sbox(pre[31:24]), sbox(pre[23:16]), sbox(pre[15:8]), sbox(pre[7:0])};

endmodule

// File: rtl/aes_key_schedule.sv
// -----------------------------------------------------------------------------
// aes_key_schedule
// Word-serial AES key expansion (128/192/256-bit keys) into an internal
// round-key store with a registered random-access read port.
//   clk, rst            clock, asynchronous active-high reset
//   start, key_in       one-cycle start pulse, cipher key (MSB = byte 0 of w[0])
//   busy, done          expansion in progress / expansion finished
//   rd_idx, rd_inv      round to read, request InvMixColumns-transformed key
//   rd_key, rd_valid    registered round key and its validity
// Optional feature macro: AES_KS_INV_EN builds the InvMixColumns read path;
// without it rd_inv is ignored.
// -----------------------------------------------------------------------------
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  input  logic [3:0]          rd_idx,
  input  logic                rd_inv,
  output logic [127:0]        rd_key,
  output logic                rd_valid
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = 4 * (NR + 1);

  ks_state_e           state;
  logic [KEY_BITS-1:0] key_q;
  logic [5:0]          wr_idx;         // i: index of the word being produced
  logic [5:0]          words_written;
  logic [2:0]          col;            // i % Nk, tracked incrementally
  logic [3:0]          rcon_idx;       // i / Nk - 1, tracked incrementally
  logic [31:0]         w_mem [NW];

  logic [31:0] prev_word, back_word, sub_word, temp_word, new_word;

  // ---------------------------------------------------------------------------
  // Expansion datapath
  // ---------------------------------------------------------------------------
  assign prev_word = w_mem[wr_idx - 6'd1];
  assign back_word = w_mem[wr_idx - 6'(NK)];

  aes_subword u_subword (
    .word_in  (prev_word),
    .rot      (col == 3'd0),
    .word_out (sub_word)
  );

  // NOTE: temp_word is assigned before any branch so every path drives it;
  // otherwise the tool infers a latch to hold its old value.
  always_comb begin
    temp_word = prev_word;
    if (col == 3'd0) begin
      temp_word = sub_word ^ {rcon(rcon_idx), 24'h0};
    end else if (NK == 8 && col == 3'd4) begin
      temp_word = sub_word;
    end
  end

  assign new_word = back_word ^ temp_word;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      key_q         <= '0;
      wr_idx        <= 6'(NK);
      words_written <= '0;
      col           <= '0;
      rcon_idx      <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            key_q         <= key_in;
            state         <= ST_LOAD;
            busy          <= 1'b1;
            done          <= 1'b0;
            words_written <= '0;
          end
        end
        ST_LOAD: begin
          wr_idx        <= 6'(NK);
          words_written <= 6'(NK);
          col           <= '0;
          rcon_idx      <= '0;
          state         <= ST_EXPAND;
        end
        ST_EXPAND: begin
          wr_idx        <= wr_idx + 6'd1;
          words_written <= words_written + 6'd1;
          if (col == 3'(NK - 1)) begin
            col      <= '0;
            rcon_idx <= rcon_idx + 4'd1;
          end else begin
            col <= col + 3'd1;
          end
          if (wr_idx == 6'(NW - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Word store: stale contents are masked by words_written, not cleared.
  // ---------------------------------------------------------------------------
  // NOTE: the store is deliberately left out of reset so it maps onto plain
  // storage; validity comes from words_written, which is reset.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD) begin
      for (int k = 0; k < NK; k++) begin
        w_mem[k] <= key_q[KEY_BITS-1-32*k -: 32];
      end
    end else if (state == ST_EXPAND) begin
      w_mem[wr_idx] <= new_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  logic         rd_in_range;
  logic         rd_hit;
  logic [5:0]   rd_base;
  logic [127:0] rd_raw;
  logic [127:0] rd_out;

  assign rd_in_range = (rd_idx <= 4'(NR));
  assign rd_base     = rd_in_range ? {rd_idx, 2'b00} : 6'd0;
  assign rd_raw      = {w_mem[rd_base],         w_mem[rd_base + 6'd1],
                        w_mem[rd_base + 6'd2],  w_mem[rd_base + 6'd3]};
  // Round r is complete once words 4r..4r+3 exist: (r+1)*4 <= words_written.
  assign rd_hit      = (({3'b000, rd_idx} + 7'd1) << 2) <= {1'b0, words_written};

`ifdef AES_KS_INV_EN
  // First and last rounds are used as-is by the equivalent inverse cipher.
  always_comb begin
    rd_out = rd_raw;
    if (rd_inv && rd_idx != 4'd0 && rd_idx < 4'(NR)) begin
      rd_out = {inv_mix_col(rd_raw[127:96]), inv_mix_col(rd_raw[95:64]),
                inv_mix_col(rd_raw[63:32]),  inv_mix_col(rd_raw[31:0])};
    end
  end
`else
  logic unused_rd_inv;
  assign unused_rd_inv = rd_inv;
  assign rd_out        = rd_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_key   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_key   <= rd_in_range ? rd_out : '0;
      rd_valid <= rd_in_range && rd_hit;
    end
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Parametrised AES key-schedule unit for 128/192/256-bit keys. It expands a cipher key word-serially into all Nr+1 round keys and holds them in an internal round-key store. The store has a random-access read port, so encryption reads rounds forward and decryption reads them in reverse from the same store. It sits between the key input register and the encrypt/decrypt round cores.

## Interface
- KEY_BITS, 128, cipher key width; legal values 128, 192, 256; Nk = KEY_BITS/32, Nr = Nk+6
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; samples key_in and begins expansion
- key_in  in  KEY_BITS  cipher key; MSB is byte 0 of w[0]
- busy  out  1  high while expanding
- done  out  1  high from completion until the next accepted start or rst
- rd_idx  in  4  round index 0..Nr
- rd_inv  in  1  select InvMixColumns-transformed key (see Configuration)
- rd_key  out  128  round key rd_idx, registered; [127:96] = w[4*rd_idx]
- rd_valid  out  1  registered; rd_key holds a fully written round

## Operation
- FSM states: IDLE, LOAD, EXPAND, DONE.
- IDLE or DONE + start: go to LOAD; clear done; set busy; reset the word counter.
- LOAD (1 cycle): write w[0..Nk-1] from key_in; i = Nk; go to EXPAND.
- EXPAND writes one word per cycle, with i running from Nk to 4(Nr+1)-1 (43/51/59):
  - temp = w[i-1]
  - if i%Nk==0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk],24'h0}
  - else if Nk==8 and i%8==4: temp = SubWord(temp)
  - w[i] = w[i-Nk] ^ temp
- After the last word is written: busy=0, done=1, state DONE.
- start while busy: ignored; the expansion in progress continues unaffected.
- Word store: 60 x 32 bits, sized by KEY_BITS. Contents are not cleared by start; rounds not yet rewritten read as invalid.
- Read port, registered:
  - rd_valid = 1 when (rd_idx+1)*4 <= words_written. Finished rounds are usable while later rounds are still expanding.
  - rd_idx > Nr: rd_key = 0, rd_valid = 0.
- Rcon: 01,02,04,08,10,20,40,80,1b,36, 8-bit GF(2^8) sequence.

## Timing
- Reset values: busy=0, done=0, rd_key=0, rd_valid=0, state IDLE, words_written=0.
- start at cycle 0 → LOAD at cycle 1 → last word written at cycle 1+4(Nr+1)-Nk.
- done rises 41 / 47 / 53 cycles after start (128/192/256).
- Round r becomes readable once words 4r..4r+3 are written. Read latency is 1 cycle from rd_idx to rd_key/rd_valid.
- A read of round r in the same cycle as its last word is written returns rd_valid=0; the next cycle returns valid.
- rst mid-expansion: immediately return to IDLE; outputs take reset values; words_written=0.

## Configuration
- AES_KS_INV_EN defined:
  - For 1 <= rd_idx <= Nr-1 with rd_inv=1, rd_key = InvMixColumns applied per 32-bit column of the stored key (FIPS-197 equivalent inverse cipher).
  - Rounds 0 and Nr are never transformed.
  - The transform is in the read path; read latency stays 1 cycle.
- AES_KS_INV_EN undefined: rd_inv is ignored; rd_key is always the raw round key; no InvMixColumns logic is built.

## Structure
- Shared package aes_pkg:
  - S-box function
  - Rcon table
  - nr_of(KEY_BITS) function
  - FSM state enum
  - InvMixColumns column function (reused by the decrypt core)
- One sub-module, aes_subword: 32-bit RotWord-optional SubWord (four S-box lookups), combinational.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start → done after 41 cycles. rd_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6 with rd_valid=1. rd_idx=0 → the key itself.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 47 cycles. rd_idx=12 → e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 53 cycles. rd_idx=14 → fe4890d1e6188d0b046df344706c631e. rd_idx=15 → 0 with rd_valid=0.
- Progressive read, KEY_BITS=128: poll rd_idx=1 after start → rd_valid=1 first at cycle 6 (word 7 written at cycle 5, valid seen the following cycle). A second start during EXPAND is ignored; done still rises at cycle 41.
- Assert rst at cycle 20 of an expansion → busy=0, done=0, rd_valid=0 immediately. A new start then completes normally.
- AES_KS_INV_EN, with a stored round whose first column is 8e4da1bc:
  - rd_inv=1 → that column reads db135345.
  - rd_idx=0 or Nr with rd_inv=1 → raw key returned.
